// File: rtl/fir_mac_engine_pkg.sv
// Shared constants and FSM state type for the FIR MAC engine.
// Imported by the interface, the MAC datapath and the engine top.
package fir_pkg;

   localparam int NTAP       = 11;
   localparam int ADDR_WIDTH = 12;
   localparam int BIT_WIDTH  = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_WAIT_X,
      S_MAC,
      S_OUT
   } state_t;

endpackage

// File: rtl/fir_mac_engine_if.sv
// AXI-Stream style valid/ready bundle used for samples in and results out.
// master drives tvalid/tdata/tlast and receives tready; slave is the mirror.
interface fir_mac_engine_if;
   import fir_pkg::*;

   logic                 tvalid;
   logic [BIT_WIDTH-1:0] tdata;
   logic                 tlast;
   logic                 tready;

   modport master (
      output tvalid,
      output tdata,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/fir_mac_engine_mac.sv
// Registered multiply-accumulate: product stage then accumulate stage.
// Ports: clk, rst, clr (zero acc), en (operands valid), tap, smp, acc.
module fir_mac
   import fir_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [BIT_WIDTH-1:0] tap,
   input  logic [BIT_WIDTH-1:0] smp,
   output logic [BIT_WIDTH-1:0] acc
);

   logic [BIT_WIDTH-1:0] prod;
   logic                 prod_v;

   // Low half of a signed product equals the low half of the unsigned
   // product, so a same-width multiply gives the truncated signed result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod   <= '0;
         prod_v <= 1'b0;
         acc    <= '0;
      end else if (clr) begin
         prod_v <= 1'b0;
         acc    <= '0;
      end else begin
         prod   <= tap * smp;
         prod_v <= en;
         if (prod_v) begin
            acc <= acc + prod;
         end
      end
   end

endmodule

// File: rtl/fir_mac_engine.sv
// 11-tap FIR engine, one MAC per cycle, history kept in an external data RAM.
// Ports: clk/rst, ap_start/data_len/ap_idle/ap_done control, ss sample
// stream in, sm result stream out, tap RAM read port, data RAM r/w ports.
module fir_mac_engine
   import fir_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ap_start,
   input  logic [31:0]           data_len,
   output logic                  ap_idle,
   output logic                  ap_done,
   fir_mac_engine_if.slave       ss,
   fir_mac_engine_if.master      sm,
   output logic                  tap_re,
   output logic [ADDR_WIDTH-1:0] tap_raddr,
   input  logic [BIT_WIDTH-1:0]  tap_rdo,
   output logic                  dat_we,
   output logic                  dat_re,
   output logic [ADDR_WIDTH-1:0] dat_waddr,
   output logic [ADDR_WIDTH-1:0] dat_raddr,
   output logic [BIT_WIDTH-1:0]  dat_wdi,
   input  logic [BIT_WIDTH-1:0]  dat_rdo
);

   localparam logic [ADDR_WIDTH-1:0] ONE   = 1;
   localparam logic [ADDR_WIDTH-1:0] NT    = ADDR_WIDTH'(NTAP);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NTAP - 1);
   // MAC stays two cycles past the last read: RAM latency + product stage.
   localparam logic [ADDR_WIDTH-1:0] FLUSH = ADDR_WIDTH'(NTAP + 1);

   state_t                state;
   state_t                nstate;
   logic [ADDR_WIDTH-1:0] k;
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] hist_addr;
   logic [31:0]           cnt;
   logic [31:0]           len;
   logic                  rd_v;
   logic                  issue;
   logic                  ss_hs;
   logic                  sm_hs;
   logic                  last_out;
   logic [BIT_WIDTH-1:0]  acc;
   logic                  unused_tlast;

   // Input tlast carries no meaning here; run length comes from data_len.
   assign unused_tlast = ss.tlast;

   assign ss_hs     = ss.tvalid & ss.tready;
   assign sm_hs     = sm.tvalid & sm.tready;
   assign last_out  = (cnt + 32'd1) == len;
   assign sm.tdata  = acc;

   // Circular history: x[n-k] sits k slots behind the newest sample.
   assign hist_addr = (wptr >= k) ? (wptr - k) : (wptr + NT - k);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE: begin
            if (ap_start && data_len != 32'd0) begin
               nstate = S_CLR;
            end
         end
         S_CLR: begin
            if (k == LAST) begin
               nstate = S_WAIT_X;
            end
         end
         S_WAIT_X: begin
            if (ss_hs) begin
               nstate = S_MAC;
            end
         end
         S_MAC: begin
            if (k == FLUSH) begin
               nstate = S_OUT;
            end
         end
         S_OUT: begin
            if (sm_hs) begin
               nstate = last_out ? S_IDLE : S_WAIT_X;
            end
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_comb begin
      ap_idle   = 1'b0;
      ss.tready = 1'b0;
      sm.tvalid = 1'b0;
      sm.tlast  = 1'b0;
      tap_re    = 1'b0;
      tap_raddr = '0;
      dat_re    = 1'b0;
      dat_raddr = '0;
      dat_we    = 1'b0;
      dat_waddr = '0;
      dat_wdi   = '0;
      issue     = 1'b0;
      unique case (state)
         S_IDLE: begin
            ap_idle = 1'b1;
         end
         S_CLR: begin
            dat_we    = 1'b1;
            dat_waddr = k;
         end
         S_WAIT_X: begin
            ss.tready = 1'b1;
            dat_we    = ss.tvalid;
            dat_waddr = wptr;
            dat_wdi   = ss.tdata;
         end
         S_MAC: begin
            if (k < NT) begin
               issue     = 1'b1;
               tap_re    = 1'b1;
               tap_raddr = k;
               dat_re    = 1'b1;
               dat_raddr = hist_addr;
            end
         end
         S_OUT: begin
            sm.tvalid = 1'b1;
            sm.tlast  = last_out;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k       <= '0;
         wptr    <= '0;
         cnt     <= '0;
         len     <= '0;
         ap_done <= 1'b0;
         rd_v    <= 1'b0;
      end else begin
         rd_v <= issue;
         unique case (state)
            S_IDLE: begin
               k <= '0;
               if (ap_start) begin
                  len     <= data_len;
                  cnt     <= '0;
                  ap_done <= (data_len == 32'd0);
               end
            end
            S_CLR: begin
               k    <= (k == LAST) ? '0 : k + ONE;
               wptr <= '0;
            end
            S_WAIT_X: begin
               k <= '0;
            end
            S_MAC: begin
               k <= k + ONE;
               if (k == FLUSH) begin
                  wptr <= (wptr == LAST) ? '0 : wptr + ONE;
               end
            end
            S_OUT: begin
               k <= '0;
               if (sm_hs) begin
                  cnt <= cnt + 32'd1;
                  if (last_out) begin
                     ap_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   fir_mac u_mac (
      .clk (clk),
      .rst (rst),
      .clr (ss_hs),
      .en  (rd_v),
      .tap (tap_rdo),
      .smp (dat_rdo),
      .acc (acc)
   );

endmodule
